// File: rtl/vector_register_file.sv
// Wide architectural register file: two combinational read ports and one synchronous write port.
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module vector_register_file #(
   parameter int NUM_REGS  = 32,
   parameter int REG_WIDTH = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 WE3,
   input  logic [4:0]           A1,
   input  logic [4:0]           A2,
   input  logic [4:0]           A3,
   input  logic [REG_WIDTH-1:0] WD3,
   output logic [REG_WIDTH-1:0] RD1,
   output logic [REG_WIDTH-1:0] RD2
);

   localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);

   logic [REG_WIDTH-1:0] regs [NUM_REGS];
   logic                 wr_en;

   // Address 0 is hardwired to zero, and addresses past the last register are unmapped.
   function automatic logic addr_valid(input logic [4:0] a);
      return (a != 5'd0) && ({1'b0, a} < NUM_REGS_L);
   endfunction

   assign wr_en = WE3 && addr_valid(A3);

   // NOTE: the whole array sits on the async reset because every register must read 0
   // immediately on reset; this rules out mapping the file onto a RAM macro.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[A3[AW-1:0]] <= WD3;
      end
   end

   function automatic logic [REG_WIDTH-1:0] read_port(input logic [4:0] a);
      if (!addr_valid(a)) begin
         return '0;
      end
`ifdef RF_WRITE_BYPASS_EN
      if (rst && wr_en && (a == A3)) begin
         return WD3;
      end
`endif
      return regs[a[AW-1:0]];
   endfunction

   assign RD1 = read_port(A1);
   assign RD2 = read_port(A2);

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file: directed scenarios followed by random traffic
// compared against an array-based reference model.
module tb_vector_register_file;

   localparam int NR = 24;
   localparam int W  = 256;

   logic         clk = 1'b0;
   logic         rst;
   logic         WE3;
   logic [4:0]   A1, A2, A3;
   logic [W-1:0] WD3, RD1, RD2;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] model [NR];

   always #5 clk = ~clk;

   vector_register_file #(.NUM_REGS(NR), .REG_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .WE3 (WE3),
      .A1  (A1),
      .A2  (A2),
      .A3  (A3),
      .WD3 (WD3),
      .RD1 (RD1),
      .RD2 (RD2)
   );

   // Expected read value from the register-file rules applied to the model array.
   function automatic logic [W-1:0] expect_rd(input logic [4:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0 || ai >= NR) return '0;
`ifdef RF_WRITE_BYPASS_EN
      if (rst === 1'b1 && WE3 === 1'b1 && a == A3) return WD3;
`endif
      return model[ai];
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NR; i++) model[i] = '0;
   endtask

   // One rising edge; the model takes the write exactly as the rules allow, then settle.
   task automatic edge_step();
      logic wr;
      wr = (rst === 1'b1) && (WE3 === 1'b1) && (A3 != 5'd0) && (int'(A3) < NR);
      @(posedge clk);
      if (wr) model[int'(A3)] = WD3;
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [W-1:0] d);
      A3 = a; WD3 = d; WE3 = 1'b1;
      edge_step();
      WE3 = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      logic [W-1:0] beef, cafe;
      beef = {8{32'hAAAABEEF}};
      cafe = {8{32'hCAFEBABE}};

      rst = 1'b0; WE3 = 1'b0; A1 = 5'd3; A2 = 5'd7; A3 = 5'd0; WD3 = '0;
      clear_model();
      #2;
      check("reset_rd1", RD1, '0);
      check("reset_rd2", RD2, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;

      // First write and readback on port 1.
      write_reg(5'd3, beef);
      A1 = 5'd3; #1;
      check("write3_rd1", RD1, beef);

      // Second write, readback on port 2, reg 3 intact.
      write_reg(5'd7, cafe);
      A2 = 5'd7; #1;
      check("write7_rd2", RD2, cafe);
      check("reg3_kept", RD1, beef);

      // Unwritten register and register zero.
      A2 = 5'd5; #1;
      check("unwritten5", RD2, '0);
      write_reg(5'd0, '1);
      A1 = 5'd0; #1;
      check("reg0_zero", RD1, '0);

      // Both ports on the same register.
      A1 = 5'd7; A2 = 5'd7; #1;
      check("same_addr_rd1", RD1, cafe);
      check("same_addr_rd2", RD2, cafe);

      // Out-of-range write is dropped, read returns 0.
      write_reg(5'd30, '1);
      A1 = 5'd30; #1;
      check("oor_read", RD1, '0);

      // Write enable low holds state over three edges.
      A3 = 5'd3; WD3 = 256'h1234; WE3 = 1'b0; A1 = 5'd3;
      repeat (3) edge_step();
      check("we0_hold", RD1, beef);

      // Asynchronous reset between clock edges.
      A1 = 5'd3; A2 = 5'd7;
      #2 rst = 1'b0;
      clear_model();
      #1;
      check("async_rst_rd1", RD1, '0);
      check("async_rst_rd2", RD2, '0);

      // Write attempt while reset held is blocked.
      A3 = 5'd4; WD3 = '1; WE3 = 1'b1;
      edge_step();
      WE3 = 1'b0;
      rst = 1'b1;
      A2 = 5'd4; #1;
      check("post_rst_rd1", RD1, '0);
      check("post_rst_rd2", RD2, '0);
      check("rst_blocks_write", RD2, '0);

      // Same-cycle read of the register being written.
      A1 = 5'd9; A2 = 5'd9; A3 = 5'd9; WD3 = 256'hFEED; WE3 = 1'b1;
      #1;
`ifdef RF_WRITE_BYPASS_EN
      check("bypass_pre_rd1", RD1, 256'hFEED);
      check("bypass_pre_rd2", RD2, 256'hFEED);
`else
      check("bypass_pre_rd1", RD1, '0);
      check("bypass_pre_rd2", RD2, '0);
`endif
      edge_step();
      WE3 = 1'b0; #1;
      check("bypass_post_rd1", RD1, 256'hFEED);
      check("bypass_post_rd2", RD2, 256'hFEED);

      // Random traffic against the model, including unmapped addresses and A1/A2 == A3.
      for (int n = 0; n < 400; n++) begin
         A3  = 5'($urandom_range(0, 31));
         A1  = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
         A2  = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
         WE3 = 1'($urandom_range(0, 1));
         WD3 = rand_word();
         #1;
         check("rand_rd1", RD1, expect_rd(A1));
         check("rand_rd2", RD2, expect_rd(A2));
         edge_step();
      end

      // Final sweep of the whole address space.
      WE3 = 1'b0;
      for (int a = 0; a < 32; a++) begin
         A1 = 5'(a); A2 = 5'(31 - a); #1;
         check("sweep_rd1", RD1, expect_rd(A1));
         check("sweep_rd2", RD2, expect_rd(A2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
